// File: rtl/sccb_pkg.sv
// sccb_pkg: shared constants, state encoding and parameter defaults for the SCCB command scheduler.
package sccb_pkg;
    localparam logic [6:0] C_ID_WRITE = 7'h21;
    localparam int unsigned ACK_TIMEOUT_DEF = 64;
    localparam int unsigned GAP_CYCLES_DEF = 1000;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;
endpackage

// File: rtl/sccb_gap_timer.sv
// sccb_gap_timer: loadable saturating down-counter; done is high while the count is zero.
module sccb_gap_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = load ? load_val : (en && count_q != '0) ? count_q - 1'b1 : count_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    assign done = count_q == '0;
endmodule

// File: rtl/sccb_cmd_sched.sv
// sccb_cmd_sched: fixed-priority arbiter sharing one SCCB master between the init sequencer and a runtime write port.
// Optional post-transaction idle gap is built when SCCB_SCHED_GAP_EN is defined.
module sccb_cmd_sched
    import sccb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       init_done,
    input  logic       req0_start,
    input  logic [6:0] req0_id,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       req1_done,
    input  logic       sccb_ready,
    output logic       start_tx,
    output logic [6:0] id,
    output logic [7:0] addr,
    output logic [7:0] data_wr,
    output logic       owner,
    output logic       busy,
    output logic       err
);
    localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

    if (ACK_TIMEOUT < 1 || GAP_CYCLES < 2) begin : g_bad_param
        $error("sccb_cmd_sched: ACK_TIMEOUT must be >= 1 and GAP_CYCLES >= 2");
    end

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [6:0] id_q, id_d;
    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic       done_q, done_d, err_q, err_d;
    logic       ack_load, ack_done, gap_load, gap_done;

    sccb_gap_timer #(.W(AW)) u_ack_timer (
        .clk(clk), .rst(rst), .load(ack_load), .en(state_q == S_WAIT_ACK),
        .load_val(AW'(ACK_TIMEOUT - 1)), .done(ack_done)
    );

`ifdef SCCB_SCHED_GAP_EN
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    // Loaded two short so IDLE returns exactly GAP_CYCLES cycles after completion is sampled.
    sccb_gap_timer #(.W(GW)) u_gap_timer (
        .clk(clk), .rst(rst), .load(gap_load), .en(state_q == S_GAP),
        .load_val(GW'(GAP_CYCLES - 2)), .done(gap_done)
    );
`else
    assign gap_done = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        id_d       = id_q;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ack_load   = 1'b0;
        gap_load   = 1'b0;
        start_tx   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req0_ready = sccb_ready;
                req1_ready = sccb_ready & init_done & ~req0_start;
                if (req0_start) begin
                    {id_d, addr_d, data_d} = {req0_id, req0_addr, req0_data};
                    owner_d = 1'b0;
                    state_d = S_ISSUE;
                end else if (req1_valid && req1_ready) begin
                    {id_d, addr_d, data_d} = {C_ID_WRITE, req1_addr, req1_data};
                    owner_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_tx = 1'b1;
                ack_load = 1'b1;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!sccb_ready) state_d = S_WAIT_DONE;
                else if (ack_done) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (sccb_ready) begin
                    done_d = owner_q;
`ifdef SCCB_SCHED_GAP_EN
                    gap_load = 1'b1;
                    state_d  = S_GAP;
`else
                    state_d  = S_IDLE;
`endif
                end
            end
`ifdef SCCB_SCHED_GAP_EN
            S_GAP: state_d = gap_done ? S_IDLE : S_GAP;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end

    assign id        = id_q;
    assign addr      = addr_q;
    assign data_wr   = data_q;
    assign owner     = owner_q;
    assign req1_done = done_q;
    assign err       = err_q;
    assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_sccb_cmd_sched.sv
// tb_sccb_cmd_sched: directed checks of arbitration, timing, timeout, reset and gap for sccb_cmd_sched.
module tb_sccb_cmd_sched;
    localparam int unsigned ACK_T = 20;
`ifdef SCCB_SCHED_GAP_EN
    localparam int GAP_EXP = 10;
`else
    localparam int GAP_EXP = 1;
`endif

    logic       clk = 0, rst = 1;
    logic       init_done = 1, req0_start = 0, req1_valid = 0, sccb_ready = 1;
    logic [6:0] req0_id = 7'h21;
    logic [7:0] req0_addr = 0, req0_data = 0, req1_addr = 0, req1_data = 0;
    logic       req0_ready, req1_ready, req1_done, start_tx, owner, busy, err;
    logic [6:0] id;
    logic [7:0] addr, data_wr;
    int checks = 0, passed = 0;

    sccb_cmd_sched #(.ACK_TIMEOUT(ACK_T), .GAP_CYCLES(10)) dut (
        .rst(rst), .clk(clk), .init_done(init_done),
        .req0_start(req0_start), .req0_id(req0_id), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready), .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready), .req1_done(req1_done), .sccb_ready(sccb_ready), .start_tx(start_tx),
        .id(id), .addr(addr), .data_wr(data_wr), .owner(owner), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (start_tx) begin ok = 1; break; end
        end
    endtask

    // Called on the negedge where start_tx is seen: master goes busy, then idles after hold cycles.
    task automatic finish_txn(input int hold);
        @(negedge clk); sccb_ready = 0;
        repeat (hold) @(negedge clk);
        sccb_ready = 1;
    endtask

    task automatic drain;
        repeat (GAP_EXP + 4) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({start_tx, busy, owner, req1_done, err, id, addr, data_wr} !== '0)
            $display("FAIL reset_outputs: got %h required 0", {start_tx, busy, owner, req1_done, err, id, addr, data_wr});
        else passed++;
        checks++;
        if (req0_ready !== 1'b1) $display("FAIL reset_req0_ready: got %b required 1", req0_ready);
        else passed++;
        rst = 0;
    endtask

    task automatic test_single_req0;
        bit saw_done = 0;
        @(negedge clk);
        req0_addr = 8'h12; req0_data = 8'h80; req0_start = 1;
        @(negedge clk);
        req0_start = 0;
        checks++;
        if ({start_tx, owner, id, addr, data_wr} !== {1'b1, 1'b0, 7'h21, 8'h12, 8'h80})
            $display("FAIL req0_issue: got %h required %h", {start_tx, owner, id, addr, data_wr}, {1'b1, 1'b0, 7'h21, 8'h12, 8'h80});
        else passed++;
        finish_txn(3);
        checks++;
        if (busy !== 1'b1) $display("FAIL req0_busy: got %b required 1", busy);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req1_done) saw_done = 1;
        end
        checks++;
        if (saw_done) $display("FAIL req0_no_done: got 1 required 0");
        else passed++;
        drain();
    endtask

    task automatic test_start_one_cycle;
        @(negedge clk);
        req0_addr = 8'h01; req0_data = 8'h02; req0_start = 1;
        @(negedge clk);
        req0_start = 0;
        @(negedge clk);
        checks++;
        if (start_tx !== 1'b0) $display("FAIL start_tx_width: got %b required 0", start_tx);
        else passed++;
        sccb_ready = 0;
        repeat (2) @(negedge clk);
        sccb_ready = 1;
        drain();
    endtask

    task automatic test_req1_init_gate;
        bit ok, leaked = 0;
        @(negedge clk);
        init_done = 0; req1_valid = 1; req1_addr = 8'h5A; req1_data = 8'h3C;
        for (int i = 0; i < 100; i++) begin
            #1 if (req1_ready || busy) leaked = 1;
            @(negedge clk);
        end
        checks++;
        if (leaked) $display("FAIL req1_gated: got ready/busy 1 required 0");
        else passed++;
        init_done = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) $display("FAIL req1_ready_after_init: got %b required 1", req1_ready);
        else passed++;
        wait_start(ok);
        req1_valid = 0;
        checks++;
        if (!ok || {owner, id, addr, data_wr} !== {1'b1, 7'h21, 8'h5A, 8'h3C})
            $display("FAIL req1_issue: got ok=%b %h required %h", ok, {owner, id, addr, data_wr}, {1'b1, 7'h21, 8'h5A, 8'h3C});
        else passed++;
        finish_txn(3);
        @(negedge clk);
        checks++;
        if (req1_done !== 1'b1) $display("FAIL req1_done_pulse: got %b required 1", req1_done);
        else passed++;
        @(negedge clk);
        checks++;
        if (req1_done !== 1'b0) $display("FAIL req1_done_width: got %b required 0", req1_done);
        else passed++;
        drain();
    endtask

    task automatic test_simultaneous;
        int n = -1;
        @(negedge clk);
        req0_addr = 8'h40; req0_data = 8'hAA; req0_start = 1;
        req1_addr = 8'h8C; req1_data = 8'h11; req1_valid = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) $display("FAIL sim_req1_blocked: got %b required 0", req1_ready);
        else passed++;
        @(negedge clk);
        req0_start = 0;
        checks++;
        if ({start_tx, owner, addr} !== {1'b1, 1'b0, 8'h40})
            $display("FAIL sim_req0_first: got %h required %h", {start_tx, owner, addr}, {1'b1, 1'b0, 8'h40});
        else passed++;
        finish_txn(2);
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (start_tx) begin n = i; break; end
        end
        req1_valid = 0;
        checks++;
        if (n != GAP_EXP + 1) $display("FAIL sim_req1_latency: got %0d required %0d", n, GAP_EXP + 1);
        else passed++;
        checks++;
        if ({owner, addr, data_wr} !== {1'b1, 8'h8C, 8'h11})
            $display("FAIL sim_req1_cmd: got %h required %h", {owner, addr, data_wr}, {1'b1, 8'h8C, 8'h11});
        else passed++;
        finish_txn(2);
        @(negedge clk);
        checks++;
        if (req1_done !== 1'b1) $display("FAIL sim_req1_done: got %b required 1", req1_done);
        else passed++;
        drain();
    endtask

    task automatic test_timeout;
        int n = -1;
        bit saw_done = 0;
        @(negedge clk);
        req0_addr = 8'h33; req0_start = 1;
        @(negedge clk);
        req0_start = 0;
        for (int i = 0; i < int'(ACK_T) + 5; i++) begin
            @(negedge clk);
            if (req1_done) saw_done = 1;
            if (err) begin n = i; break; end
        end
        checks++;
        if (n != int'(ACK_T)) $display("FAIL timeout_latency: got %0d required %0d", n, ACK_T);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL timeout_idle: got busy %b required 0", busy);
        else passed++;
        @(negedge clk);
        if (req1_done) saw_done = 1;
        checks++;
        if (err !== 1'b0 || saw_done) $display("FAIL timeout_pulses: got err=%b done=%b required 0", err, saw_done);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid;
        bit ok, bad = 0;
        @(negedge clk);
        req1_addr = 8'h77; req1_data = 8'h01; req1_valid = 1;
        wait_start(ok);
        req1_valid = 0;
        @(negedge clk); sccb_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (!ok || {busy, start_tx, owner, req1_done, err, id, addr, data_wr} !== '0)
            $display("FAIL reset_mid: got ok=%b %h required 0", ok, {busy, start_tx, owner, req1_done, err, id, addr, data_wr});
        else passed++;
        @(negedge clk);
        sccb_ready = 1; rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req1_done || busy) bad = 1;
        end
        checks++;
        if (bad) $display("FAIL reset_mid_after: got done/busy 1 required 0");
        else passed++;
    endtask

    task automatic test_gap;
        int n = -1;
        @(negedge clk);
        req0_addr = 8'h55; req0_start = 1;
        @(negedge clk);
        req0_start = 0;
        finish_txn(3);
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            if (req0_ready) begin n = i; break; end
        end
        checks++;
        if (n != GAP_EXP) $display("FAIL gap_length: got %0d required %0d", n, GAP_EXP);
        else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_start_one_cycle();
        test_req1_init_gate();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_gap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
